// File: rtl/tinycpu_pkg.sv
// Shared TinyCPU definitions: sequencer state encoding, opcodes and the NOP word.
package tinycpu_pkg;

    localparam int unsigned INSN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_FAULT  = 3'd4
    } seq_state_t;

    localparam logic [3:0] OP_LI  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_NOP = 4'hF;

    localparam logic [INSN_W-1:0] NOP_INSN = 16'hFFFF;

    // Opcode field of an instruction word.
    function automatic logic [3:0] opcode(input logic [INSN_W-1:0] insn);
        return insn[15:12];
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction-memory fetch port: request/address out, acknowledge/data back.
interface cpu_sequencer_if
    import tinycpu_pkg::*;
#(
    parameter int unsigned PC_W = 8
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INSN_W-1:0] imem_rdata;

    // Sequencer side issues requests.
    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    // Memory side answers them.
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/seq_fetch_timer.sv
// Counts FETCH cycles without an acknowledge; flags the cycle that exhausts the budget.
module seq_fetch_timer #(
    parameter int unsigned FETCH_TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned       CNT_W = $clog2(FETCH_TMO + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FETCH_TMO - 1);

    logic [CNT_W-1:0] cnt;

    // Wait-cycle counter, restarted whenever the fetch ends or is not in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // This cycle is the FETCH_TMO-th one without an ack.
    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// TinyCPU fetch/decode/execute sequencer: owns the FSM, PC and instruction register.
module cpu_sequencer
    import tinycpu_pkg::*;
#(
    parameter int unsigned      PC_W      = 8,
    parameter logic [PC_W-1:0]  RESET_PC  = '0,
    parameter int unsigned      FETCH_TMO = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    cpu_sequencer_if.master    imem,
    output logic [INSN_W-1:0]  ir,
    input  logic               cu_reg_we,
    input  logic               cu_jump_en,
    input  logic [7:0]         cu_imm_val,
    output logic               rf_we,
    output logic [PC_W-1:0]    pc,
    output logic               retire,
    output logic               busy,
    output logic               fault
);
    seq_state_t state;
    logic       in_fetch;
    logic       tmo_expired;

    assign in_fetch = (state == ST_FETCH);

    seq_fetch_timer #(.FETCH_TMO(FETCH_TMO)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_fetch || imem.imem_ack),
        .enable  (in_fetch && !imem.imem_ack),
        .expired (tmo_expired)
    );

    // Sequencer FSM with PC and instruction register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            ir    <= NOP_INSN;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        ir    <= imem.imem_rdata;
                        state <= ST_DECODE;
                    end else if (tmo_expired) begin
                        state <= ST_FAULT;
                    end
                end
                ST_DECODE: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    pc    <= cu_jump_en ? cu_imm_val[PC_W-1:0] : pc + PC_W'(1);
                    state <= run ? ST_FETCH : ST_IDLE;
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only the registered state, so imem_ack never reaches imem_req.
    assign imem.imem_req  = in_fetch;
    assign imem.imem_addr = pc;
    assign rf_we          = (state == ST_EXEC) && cu_reg_we;
    assign retire         = (state == ST_EXEC);
    assign busy           = in_fetch || (state == ST_DECODE) || (state == ST_EXEC);
    assign fault          = (state == ST_FAULT);

endmodule
